// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter in front of a single-port falling-edge SRAM: one access per grant, IDLE/ACCESS sequencing.
// Round-robin by default; define SRAM_ARB_FIXED_PRIORITY_EN to give requester A absolute priority.
module sram_port_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,

    input  logic                  Req_A,
    input  logic                  Write_A,
    input  logic [ADDR_WIDTH-1:0] Addr_A,
    input  logic [DATA_WIDTH-1:0] Wdata_A,
    output logic                  Grant_A,
    output logic                  Done_A,
    output logic [DATA_WIDTH-1:0] Rdata_A,

    input  logic                  Req_B,
    input  logic                  Write_B,
    input  logic [ADDR_WIDTH-1:0] Addr_B,
    input  logic [DATA_WIDTH-1:0] Wdata_B,
    output logic                  Grant_B,
    output logic                  Done_B,
    output logic [DATA_WIDTH-1:0] Rdata_B,

    output logic [ADDR_WIDTH-1:0] Sram_Address,
    output logic [DATA_WIDTH-1:0] Sram_Wdata,
    output logic                  Sram_Write_Enable,
    output logic                  Sram_Read_Enable,
    input  logic [DATA_WIDTH-1:0] Sram_Rdata
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                  state_q;
    logic                    owner_b_q;
    logic                    grant_a_q, grant_b_q;
    logic                    done_a_q, done_b_q;
    logic [DATA_WIDTH-1:0]   rdata_a_q, rdata_b_q;
    logic [ADDR_WIDTH-1:0]   sram_addr_q;
    logic [DATA_WIDTH-1:0]   sram_wdata_q;
    logic                    sram_we_q, sram_re_q;
    logic                    pick_b;

`ifndef SRAM_ARB_FIXED_PRIORITY_EN
    // Set when B was the most recent winner; reset leaves it set so A takes the first tie.
    logic                    last_b_q;
`endif

    always_comb begin
        // NOTE: give every always_comb output a default first so no path can infer a latch.
        pick_b = 1'b0;
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
        pick_b = Req_B && !Req_A;
`else
        pick_b = Req_B && (!Req_A || !last_b_q);
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            state_q      <= IDLE;
            owner_b_q    <= 1'b0;
            grant_a_q    <= 1'b0;
            grant_b_q    <= 1'b0;
            done_a_q     <= 1'b0;
            done_b_q     <= 1'b0;
            rdata_a_q    <= '0;
            rdata_b_q    <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_we_q    <= 1'b0;
            sram_re_q    <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIORITY_EN
            last_b_q     <= 1'b1;
`endif
        end else begin
            grant_a_q <= 1'b0;
            grant_b_q <= 1'b0;
            done_a_q  <= 1'b0;
            done_b_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Req_A || Req_B) begin
                        owner_b_q    <= pick_b;
                        grant_a_q    <= !pick_b;
                        grant_b_q    <= pick_b;
                        sram_addr_q  <= pick_b ? Addr_B  : Addr_A;
                        sram_wdata_q <= pick_b ? Wdata_B : Wdata_A;
                        sram_we_q    <= pick_b ? Write_B  : Write_A;
                        sram_re_q    <= pick_b ? !Write_B : !Write_A;
`ifndef SRAM_ARB_FIXED_PRIORITY_EN
                        last_b_q     <= pick_b;
`endif
                        state_q      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // The SRAM completed the operation on the falling edge of this cycle.
                    sram_we_q <= 1'b0;
                    sram_re_q <= 1'b0;
                    done_a_q  <= !owner_b_q;
                    done_b_q  <= owner_b_q;
                    if (sram_re_q) begin
                        if (owner_b_q) rdata_b_q <= Sram_Rdata;
                        else           rdata_a_q <= Sram_Rdata;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Grant_A           = grant_a_q;
    assign Grant_B           = grant_b_q;
    assign Done_A            = done_a_q;
    assign Done_B            = done_b_q;
    assign Rdata_A           = rdata_a_q;
    assign Rdata_B           = rdata_b_q;
    assign Sram_Address      = sram_addr_q;
    assign Sram_Wdata        = sram_wdata_q;
    assign Sram_Write_Enable = sram_we_q;
    assign Sram_Read_Enable  = sram_re_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: falling-edge SRAM model, directed scenarios and random traffic
// checked against a transaction-level reference of the arbitration rules.
module tb_sram_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          Req_A, Write_A, Req_B, Write_B;
    logic [AW-1:0] Addr_A, Addr_B;
    logic [DW-1:0] Wdata_A, Wdata_B;
    logic          Grant_A, Grant_B, Done_A, Done_B;
    logic [DW-1:0] Rdata_A, Rdata_B;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic          sram_we, sram_re;
    logic [DW-1:0] sram_rdata = '0;

    logic [DW-1:0] sram_mem [256];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .Clk_In(clk), .Reset_In(rst),
        .Req_A(Req_A), .Write_A(Write_A), .Addr_A(Addr_A), .Wdata_A(Wdata_A),
        .Grant_A(Grant_A), .Done_A(Done_A), .Rdata_A(Rdata_A),
        .Req_B(Req_B), .Write_B(Write_B), .Addr_B(Addr_B), .Wdata_B(Wdata_B),
        .Grant_B(Grant_B), .Done_B(Done_B), .Rdata_B(Rdata_B),
        .Sram_Address(sram_addr), .Sram_Wdata(sram_wdata),
        .Sram_Write_Enable(sram_we), .Sram_Read_Enable(sram_re),
        .Sram_Rdata(sram_rdata)
    );

    // Single-port SRAM macro acting on the falling edge.
    always @(negedge clk) begin
        if (sram_we) sram_mem[sram_addr] <= sram_wdata;
        if (sram_re) sram_rdata <= sram_mem[sram_addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        Req_A = 1'b0;
        Req_B = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Runs one access for a single requester; returns {Grant_A,Grant_B,Done_A,Done_B,WE,RE}
    // sampled one and two cycles after the request is first sampled.
    task automatic access(input logic use_b, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, output logic [5:0] at_grant,
                          output logic [5:0] at_done);
        if (use_b) begin
            Req_B = 1'b1; Write_B = wr; Addr_B = addr; Wdata_B = data;
        end else begin
            Req_A = 1'b1; Write_A = wr; Addr_A = addr; Wdata_A = data;
        end
        tick();
        at_grant = {Grant_A, Grant_B, Done_A, Done_B, sram_we, sram_re};
        Req_A = 1'b0;
        Req_B = 1'b0;
        tick();
        at_done = {Grant_A, Grant_B, Done_A, Done_B, sram_we, sram_re};
    endtask

    task automatic test_reset;
        logic [5:0] flags;
        do_reset();
        tests_run++;
        if ({Grant_A, Grant_B, Done_A, Done_B, Rdata_A, Rdata_B, sram_addr, sram_wdata,
             sram_we, sram_re} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: outputs not all zero (Rdata_A=%h Rdata_B=%h addr=%h we=%b re=%b)",
                     Rdata_A, Rdata_B, sram_addr, sram_we, sram_re);
        end
        tick();
        tick();
        flags = {Grant_A, Grant_B, Done_A, Done_B, sram_we, sram_re};
        tests_run++;
        if (flags !== 6'b000000) begin
            tests_failed++;
            $display("FAIL idle_no_request: flags=%b expected=000000", flags);
        end
    endtask

    task automatic test_write_read;
        logic [5:0] g, d;
        access(1'b0, 1'b1, 8'h10, 16'hBEEF, g, d);
        tests_run++;
        if (g !== 6'b100010) begin
            tests_failed++;
            $display("FAIL wr_grant: flags=%b expected=100010", g);
        end
        tests_run++;
        if (d !== 6'b001000) begin
            tests_failed++;
            $display("FAIL wr_done: flags=%b expected=001000", d);
        end
        access(1'b0, 1'b0, 8'h10, 16'h0000, g, d);
        tests_run++;
        if (g !== 6'b100001) begin
            tests_failed++;
            $display("FAIL rd_grant: flags=%b expected=100001", g);
        end
        tests_run++;
        if (d !== 6'b001000 || Rdata_A !== 16'hBEEF) begin
            tests_failed++;
            $display("FAIL rd_done: flags=%b Rdata_A=%h expected flags=001000 Rdata_A=beef", d, Rdata_A);
        end
    endtask

`ifndef SRAM_ARB_FIXED_PRIORITY_EN
    task automatic test_round_robin;
        int seq[$];
        int exp_seq[4] = '{0, 1, 0, 1};
        int na = 0;
        int nb = 0;
        do_reset();
        Req_A = 1'b1; Write_A = 1'b1; Addr_A = 8'h01; Wdata_A = 16'h1111;
        Req_B = 1'b1; Write_B = 1'b1; Addr_B = 8'h02; Wdata_B = 16'h2222;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (Grant_A) begin
                seq.push_back(0);
                na++;
                if (na == 1) begin Write_A = 1'b0; Addr_A = 8'h02; end
                else Req_A = 1'b0;
            end
            if (Grant_B) begin
                seq.push_back(1);
                nb++;
                if (nb == 1) begin Write_B = 1'b0; Addr_B = 8'h01; end
                else Req_B = 1'b0;
            end
        end
        Req_A = 1'b0;
        Req_B = 1'b0;
        tests_run++;
        if (seq.size() != 4) begin
            tests_failed++;
            $display("FAIL rr_grant_count: got %0d grants, expected 4", seq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (seq[i] != exp_seq[i]) begin
                    tests_failed++;
                    $display("FAIL rr_order[%0d]: got %s expected %s", i,
                             seq[i] ? "B" : "A", exp_seq[i] ? "B" : "A");
                end
            end
        end
        tests_run++;
        if (Rdata_A !== 16'h2222 || Rdata_B !== 16'h1111) begin
            tests_failed++;
            $display("FAIL rr_rdata: Rdata_A=%h Rdata_B=%h expected 2222/1111", Rdata_A, Rdata_B);
        end
    endtask
`else
    task automatic test_fixed_priority;
        int seq[$];
        int exp_seq[4] = '{0, 0, 0, 1};
        int na = 0;
        do_reset();
        Req_A = 1'b1; Write_A = 1'b0; Addr_A = 8'h21; Wdata_A = '0;
        Req_B = 1'b1; Write_B = 1'b0; Addr_B = 8'h22; Wdata_B = '0;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (Grant_A) begin
                seq.push_back(0);
                na++;
                if (na == 3) Req_A = 1'b0;
            end
            if (Grant_B) begin
                seq.push_back(1);
                Req_B = 1'b0;
            end
        end
        Req_A = 1'b0;
        Req_B = 1'b0;
        tests_run++;
        if (seq.size() != 4) begin
            tests_failed++;
            $display("FAIL fp_grant_count: got %0d grants, expected 4", seq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (seq[i] != exp_seq[i]) begin
                    tests_failed++;
                    $display("FAIL fp_order[%0d]: got %s expected %s", i,
                             seq[i] ? "B" : "A", exp_seq[i] ? "B" : "A");
                end
            end
        end
    endtask
`endif

    task automatic test_boundary;
        logic [5:0] g, d;
        access(1'b1, 1'b1, 8'h80, 16'h3C3C, g, d);
        access(1'b1, 1'b0, 8'h80, 16'h0000, g, d);
        tests_run++;
        if (Rdata_B !== 16'h3C3C) begin
            tests_failed++;
            $display("FAIL bnd_setup: Rdata_B=%h expected 3c3c", Rdata_B);
        end
        access(1'b1, 1'b1, 8'hFF, 16'hA5A5, g, d);
        tests_run++;
        if (g !== 6'b010010 || d !== 6'b000100 || Rdata_B !== 16'h3C3C) begin
            tests_failed++;
            $display("FAIL bnd_wr_ff: grant=%b done=%b Rdata_B=%h expected 010010/000100/3c3c",
                     g, d, Rdata_B);
        end
        access(1'b1, 1'b1, 8'h00, 16'h5A5A, g, d);
        tests_run++;
        if (Rdata_B !== 16'h3C3C) begin
            tests_failed++;
            $display("FAIL bnd_wr_00: Rdata_B=%h expected 3c3c", Rdata_B);
        end
        access(1'b1, 1'b0, 8'hFF, 16'h0000, g, d);
        tests_run++;
        if (d !== 6'b000100 || Rdata_B !== 16'hA5A5) begin
            tests_failed++;
            $display("FAIL bnd_rd_ff: done=%b Rdata_B=%h expected 000100/a5a5", d, Rdata_B);
        end
        access(1'b1, 1'b0, 8'h00, 16'h0000, g, d);
        tests_run++;
        if (Rdata_B !== 16'h5A5A) begin
            tests_failed++;
            $display("FAIL bnd_rd_00: Rdata_B=%h expected 5a5a", Rdata_B);
        end
    endtask

    task automatic test_reset_mid_access;
        logic [5:0] g, d;
        access(1'b0, 1'b1, 8'h33, 16'h7777, g, d);
        access(1'b0, 1'b0, 8'h33, 16'h0000, g, d);
        tests_run++;
        if (Rdata_A !== 16'h7777) begin
            tests_failed++;
            $display("FAIL rma_setup: Rdata_A=%h expected 7777", Rdata_A);
        end
        Req_A = 1'b1; Write_A = 1'b0; Addr_A = 8'h33;
        tick();
        tests_run++;
        if ({Grant_A, sram_re} !== 2'b11) begin
            tests_failed++;
            $display("FAIL rma_grant: Grant_A=%b re=%b expected 1/1", Grant_A, sram_re);
        end
        Req_A = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if ({Grant_A, Grant_B, Done_A, Done_B, Rdata_A, Rdata_B, sram_addr, sram_wdata,
             sram_we, sram_re} !== '0) begin
            tests_failed++;
            $display("FAIL rma_outputs: Done_A=%b Rdata_A=%h we=%b re=%b expected all zero",
                     Done_A, Rdata_A, sram_we, sram_re);
        end
        tick();
        tests_run++;
        if ({Done_A, Done_B, sram_we, sram_re} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL rma_no_done: Done_A=%b Done_B=%b expected 0/0", Done_A, Done_B);
        end
        Req_A = 1'b1; Write_A = 1'b0; Addr_A = 8'h10;
        Req_B = 1'b1; Write_B = 1'b0; Addr_B = 8'h10;
        tick();
        tests_run++;
        if ({Grant_A, Grant_B} !== 2'b10) begin
            tests_failed++;
            $display("FAIL rma_first_tie: grants=%b expected 10", {Grant_A, Grant_B});
        end
        Req_A = 1'b0;
        tick();
        tick();
        Req_B = 1'b0;
        tick();
    endtask

    task automatic test_random;
        logic [5:0]    g, d;
        logic [DW-1:0] mem_ref [256];
        logic          m_busy, m_b, m_w, m_last_b, win_b;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_data, m_ra, m_rb;
        logic [5:0]    e_flags, o_flags;
        logic          pend_a, pend_b;
        int            errs = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            mem_ref[8'hC0 + i] = 16'(i * 16'h0101 + 16'h1000);
            access(1'b0, 1'b1, AW'(8'hC0 + i), mem_ref[8'hC0 + i], g, d);
        end
        m_busy = 1'b0; m_last_b = 1'b1; m_ra = '0; m_rb = '0;
        m_b = 1'b0; m_w = 1'b0; m_addr = '0; m_data = '0;
        pend_a = 1'b0; pend_b = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            // Reference: one access per two cycles, winner chosen from requests seen while idle.
            e_flags = '0;
            if (!m_busy) begin
                if (Req_A || Req_B) begin
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
                    win_b = !Req_A;
`else
                    win_b = !Req_A || (Req_B && !m_last_b);
`endif
                    m_last_b = win_b;
                    m_b    = win_b;
                    m_w    = win_b ? Write_B : Write_A;
                    m_addr = win_b ? Addr_B  : Addr_A;
                    m_data = win_b ? Wdata_B : Wdata_A;
                    m_busy = 1'b1;
                    e_flags = {!win_b, win_b, 2'b00, m_w, !m_w};
                end
            end else begin
                m_busy = 1'b0;
                e_flags = {2'b00, !m_b, m_b, 2'b00};
                if (m_w) mem_ref[m_addr] = m_data;
                else if (m_b) m_rb = mem_ref[m_addr];
                else m_ra = mem_ref[m_addr];
            end
            tick();
            o_flags = {Grant_A, Grant_B, Done_A, Done_B, sram_we, sram_re};
            tests_run++;
            if (o_flags !== e_flags || Rdata_A !== m_ra || Rdata_B !== m_rb ||
                (m_busy && (sram_addr !== m_addr || (m_w && sram_wdata !== m_data)))) begin
                tests_failed++;
                if (errs++ < 10)
                    $display("FAIL rand_cycle%0d: flags=%b exp=%b Ra=%h exp=%h Rb=%h exp=%h addr=%h exp=%h",
                             c, o_flags, e_flags, Rdata_A, m_ra, Rdata_B, m_rb, sram_addr, m_addr);
            end
            tests_run++;
            if ((Grant_A && Grant_B) || (Done_A && Done_B) || (sram_we && sram_re) ||
                ((sram_we || sram_re) !== (Grant_A || Grant_B))) begin
                tests_failed++;
                if (errs++ < 10)
                    $display("FAIL rand_invariant%0d: flags=%b", c, o_flags);
            end
            if (Grant_A) pend_a = 1'b0;
            if (Grant_B) pend_b = 1'b0;
            if (!pend_a) begin
                Req_A = ($urandom_range(0, 2) != 0);
                Write_A = 1'($urandom); Addr_A = AW'(8'hC0 + $urandom_range(0, 15));
                Wdata_A = DW'($urandom);
                pend_a = Req_A;
            end
            if (!pend_b) begin
                Req_B = ($urandom_range(0, 2) != 0);
                Write_B = 1'($urandom); Addr_B = AW'(8'hC0 + $urandom_range(0, 15));
                Wdata_B = DW'($urandom);
                pend_b = Req_B;
            end
        end
        Req_A = 1'b0;
        Req_B = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        Req_A = 1'b0; Write_A = 1'b0; Addr_A = '0; Wdata_A = '0;
        Req_B = 1'b0; Write_B = 1'b0; Addr_B = '0; Wdata_B = '0;
        test_reset();
        test_write_read();
`ifndef SRAM_ARB_FIXED_PRIORITY_EN
        test_round_robin();
`else
        test_fixed_priority();
`endif
        test_boundary();
        test_reset_mid_access();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port 256x16 SRAM between two independent requesters, A and B.
- Arbitrates per access, round-robin by default, and sequences exactly one read or write per granted access.
- Drives the SRAM's enable, address and data pins and returns read data and completion strobes to each requester.
- Sits between the SRAM macro and its two client blocks.
- The SRAM samples and updates on the falling clock edge. This block operates on the rising edge only.

Parameters:
- ADDR_WIDTH, 8: address width of requesters and SRAM.
- DATA_WIDTH, 16: data width of requesters and SRAM.

Ports:
- Clk_In  in  1  system clock, rising-edge.
- Reset_In  in  1  reset, synchronous, active-high.
- Req_A  in  1  requester A access request, level.
- Write_A  in  1  A operation: 1 = write, 0 = read.
- Addr_A  in  ADDR_WIDTH  A address.
- Wdata_A  in  DATA_WIDTH  A write data.
- Grant_A  out  1  one-cycle pulse: A's command accepted.
- Done_A  out  1  one-cycle pulse: A's access complete.
- Rdata_A  out  DATA_WIDTH  A read data, valid while Done_A=1 after a read; held until A's next read.
- Req_B, Write_B, Addr_B, Wdata_B, Grant_B, Done_B, Rdata_B: same as A, for requester B.
- Sram_Address  out  ADDR_WIDTH  to SRAM Address_In.
- Sram_Wdata  out  DATA_WIDTH  to SRAM Data_In.
- Sram_Write_Enable  out  1  to SRAM Write_Enable.
- Sram_Read_Enable  out  1  to SRAM Read_Enable.
- Sram_Rdata  in  DATA_WIDTH  from SRAM Data_Out.

Behaviour:
- Reset:
  - Every output is registered and clears to 0 on the rising edge where Reset_In=1.
  - State goes to IDLE and the round-robin pointer is set so that A wins the first tie.
  - Reset overrides all other activity. An access in progress is aborted with no Done pulse and no Rdata update.
  - A write interrupted in ACCESS may or may not land in the SRAM; that is undefined.
- FSM states: IDLE, ACCESS.
- IDLE, no request: with Req_A=Req_B=0, stay in IDLE with both SRAM enables at 0.
- IDLE, request present: on the rising edge with any Req asserted:
  - Pick the winner.
  - Latch the winner's Write, Addr and Wdata into the Sram_* registers.
  - Set exactly one of Sram_Write_Enable or Sram_Read_Enable.
  - Pulse that requester's Grant for the next cycle and go to ACCESS.
- ACCESS:
  - The SRAM performs the operation on the falling edge inside this cycle.
  - On the next rising edge, clear both enables and return to IDLE.
  - Pulse the winner's Done for one cycle.
  - For a read, capture Sram_Rdata into the winner's Rdata on that same edge.
- Timing:
  - Grant is seen 1 cycle after Req is sampled.
  - Done is seen 2 cycles after Req is sampled; read data is valid with Done.
  - Peak throughput is one access per 2 cycles.
  - Requests are sampled only in IDLE, so arbitration never occurs in ACCESS.
- Request hold rules:
  - A requester holds Req, Write, Addr and Wdata stable until it sees its Grant.
  - After Grant it may drop Req or keep it asserted to request again. A still-asserted Req is re-arbitrated in the IDLE cycle after ACCESS.
- Round-robin arbitration:
  - Only one request: it wins.
  - Both requesting: the requester not served last wins.
  - The pointer updates only when a grant is issued.
  - Both held continuously gives A, B, A, B, ...
- Output invariants:
  - Grant_A and Grant_B are never 1 together; the same holds for Done_A and Done_B.
  - Sram_Write_Enable and Sram_Read_Enable are never 1 together.
  - The enables are 1 only in ACCESS.
- Rdata_A and Rdata_B change only on a completed read by their own requester. A write leaves Rdata unchanged.

Optional Feature:
- SRAM_ARB_FIXED_PRIORITY_EN defined:
  - A always wins when both request; B is served only when Req_A=0 in IDLE.
  - The round-robin pointer is not implemented.
- SRAM_ARB_FIXED_PRIORITY_EN undefined: round-robin as described in Behaviour.

Test Plan:
- Write then read, single requester:
  - Stimulus: A writes 16'hBEEF to address 8'h10, then A reads 8'h10.
  - Required: Grant_A at cycle +1 and Done_A at cycle +2 for each access; Rdata_A=16'hBEEF with the second Done_A; Grant_B and Done_B stay 0.
- Round-robin under contention:
  - Stimulus: Req_A and Req_B held high for 4 accesses. A writes 16'h1111 to 8'h01, B writes 16'h2222 to 8'h02, A reads 8'h02, B reads 8'h01.
  - Required: grants alternate A, B, A, B; Rdata_A=16'h2222; Rdata_B=16'h1111.
- Boundary addresses:
  - Stimulus: B writes 16'hA5A5 to 8'hFF and 16'h5A5A to 8'h00, then reads both.
  - Required: values return correctly with no aliasing; Rdata_B is unchanged by the writes.
- Reset mid-access:
  - Stimulus: Reset_In=1 on the edge that would end ACCESS for a read by A.
  - Required: no Done_A pulse, Rdata_A=0, all outputs 0, state IDLE. The next simultaneous request is won by A.
- Fixed priority (with SRAM_ARB_FIXED_PRIORITY_EN):
  - Stimulus: Req_A and Req_B held for 3 accesses, then Req_A dropped.
  - Required: grants are A, A, A, then B.
- Enable exclusivity:
  - Stimulus: random Req/Write/Addr traffic for 1000 cycles.
  - Required: assertions never see both enables high, both Grants high, or an enable high outside ACCESS.
